alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational 64-bit ALU (add/sub/and/xor, with overflow flag) between two requesters.
- Arbitrates round-robin and registers the winner's operands onto the ALU inputs.
- Captures the result and overflow one cycle later and returns them on a response channel with valid/ready backpressure.
- Sits between the datapath clients and the shared ALU instance.

Parameters:
WIDTH, 64, operand/result width in bits.
CNT_W, 16, width of the per-requester completion counters.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand a (signed)
req0_b  input  WIDTH  requester 0 operand b (signed)
req0_op  input  2  00 add, 01 sub (a-b), 10 and, 11 xor
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
alu_a  output  WIDTH  operand a to shared ALU
alu_b  output  WIDTH  operand b to shared ALU
alu_ctrl  output  2  op code to shared ALU
alu_out  input  WIDTH  shared ALU result, combinational from alu_a/alu_b/alu_ctrl
alu_overflow  input  1  shared ALU signed overflow
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_data  output  WIDTH  captured result
resp_overflow  output  1  captured overflow; forced 0 for op 10/11
resp_id  output  1  requester that issued the result
done_cnt0  output  CNT_W  completed transactions, requester 0
done_cnt1  output  CNT_W  completed transactions, requester 1

Behaviour:
- Clock and reset: single clock domain, clk; rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE; round-robin pointer = last_grant = 1, so requester 0 wins first.
  - alu_a, alu_b, alu_ctrl, resp_data = 0; resp_overflow, resp_valid, resp_id = 0; done_cnt0/1 = 0.
  - reqX_ready = 0 while in reset.
- IDLE:
  - Grant selection:
    - Only one valid: grant that requester.
    - Both valid: grant the requester that is NOT last_grant.
  - reqX_ready is combinational: 1 only for the granted requester and only in IDLE.
  - On valid&ready: latch a/b/op into alu_a/alu_b/alu_ctrl, latch resp_id, set last_grant, go to EXEC.
  - No valid: stay in IDLE; registers hold.
- EXEC (exactly 1 cycle):
  - alu_* registers are stable the whole cycle.
  - At the clock edge: capture alu_out into resp_data.
  - resp_overflow = alu_overflow when alu_ctrl is 00/01, else 0.
  - Set resp_valid = 1; go to RESP.
- RESP:
  - Hold resp_valid, resp_data, resp_overflow, resp_id stable until resp_ready=1.
  - On resp_valid&resp_ready: clear resp_valid, increment done_cnt[resp_id], go to IDLE.
  - alu_* hold their last values; they are not cleared.
- Latency and throughput:
  - Accept to resp_valid = 2 clk edges.
  - Minimum 3 cycles per transaction with resp_ready held high.
- Handshake rules:
  - Requesters hold valid/a/b/op stable until ready.
  - reqX_ready is never asserted in EXEC or RESP.
  - At most one ready is high in any cycle.
  - A valid dropped before ready is not an error; it is simply not granted.
- Fairness:
  - Both requesters continuously valid: grants strictly alternate 0,1,0,1.
  - A lone requester may be granted back-to-back.
- Counters: done_cntX wraps modulo 2^CNT_W (all-ones to 0), with no saturation and no flag.
- Arithmetic: the block performs no arithmetic on data; width and sign handling belong to the ALU. resp_data is alu_out bit-for-bit.
- Reset mid-operation: an in-flight transaction is discarded with no response, and every register returns to its reset value immediately.
- resp_ready high outside RESP: ignored.

Test Plan:
- Single sub: req0 a=5, b=3, op=01 -> req0_ready for 1 cycle; 2 edges later resp_valid=1, resp_data=2, resp_overflow=0, resp_id=0; done_cnt0=1 after the handshake.
- Sub overflow: req1 a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF (-1), op=01 -> resp_data=0x8000_0000_0000_0000, resp_overflow=1, resp_id=1.
- Contention: both valid from reset, 4 ops each, resp_ready=1 -> resp_id sequence 0,1,0,1,0,1,0,1; never both readys high; done_cnt0=done_cnt1=4.
- Backpressure and logical-op flag: resp_ready=0 for 5 cycles after resp_valid -> data/id constant and no new ready. Separately, op=10 with the ALU model forcing alu_overflow=1 -> resp_overflow=0.
- Reset mid-op: assert rst_n=0 asynchronously during EXEC -> resp_valid stays 0 and all outputs are 0 without waiting for a clk edge. After release, a req1-only request is granted first and completes normally.
- Counter wrap: with CNT_W=4, 17 req0 transactions -> done_cnt0 goes 15 -> 0 -> 1; done_cnt1 stays 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one combinational ALU (add/sub/and/xor with signed
//               overflow) between two requesters. A round-robin arbiter picks
//               a winner in IDLE and registers its operands onto the ALU
//               inputs. The ALU result and overflow flag are captured one
//               cycle later and presented on a valid/ready response channel.
//               Per-requester completion counters wrap silently.
//
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               reqN_valid/ready     - request handshake, requester N (0/1)
//               reqN_a/b/op          - operands and opcode, requester N
//               alu_a/alu_b/alu_ctrl - registered operands/opcode to the ALU
//               alu_out/alu_overflow - combinational ALU result and flag
//               resp_valid/ready     - response handshake
//               resp_data/overflow   - captured result and overflow flag
//               resp_id              - requester that issued the result
//               done_cnt0/1          - completed transactions per requester
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_overflow,
    output logic             resp_id,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t r_state;
    logic   r_last_grant;   // requester granted most recently
    logic   w_idle;
    logic   w_grant0;
    logic   w_grant1;

    // rst_n is folded in so that no ready is visible while reset is held,
    // even though the state register already reads IDLE.
    assign w_idle = rst_n && (r_state == ST_IDLE);

    // Contention goes to the requester that was not granted last time.
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_ctrl      <= 2'b00;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_overflow <= 1'b0;
            resp_id       <= 1'b0;
            done_cnt0     <= '0;
            done_cnt1     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        alu_a        <= w_grant1 ? req1_a  : req0_a;
                        alu_b        <= w_grant1 ? req1_b  : req0_b;
                        alu_ctrl     <= w_grant1 ? req1_op : req0_op;
                        resp_id      <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_data     <= alu_out;
                    // Overflow is meaningless for the logical ops (1x).
                    resp_overflow <= alu_overflow && !alu_ctrl[1];
                    resp_valid    <= 1'b1;
                    r_state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (resp_id) begin
                            done_cnt1 <= done_cnt1 + c_CNT_ONE;
                        end else begin
                            done_cnt0 <= done_cnt0 + c_CNT_ONE;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
